// File: rtl/m68k_bus_ctrl_if.sv
// 68000 bus-cycle handshake bundle between the CPU/decoder/arbiter side and the bus controller.
interface m68k_bus_ctrl_if;
  logic       cpu_as_n;
  logic       cpu_rw;
  logic       prog_rom_cs;
  logic       mem_cs;
  logic       pal_cs;
  logic       io_cs;
  logic       rom_ack;
  logic       rom_req;
  logic       cpu_dtack_n;
  logic       cpu_berr_n;
  logic [2:0] region;
  logic       busy;

  modport master (
    output cpu_as_n, cpu_rw, prog_rom_cs, mem_cs, pal_cs, io_cs, rom_ack,
    input  rom_req, cpu_dtack_n, cpu_berr_n, region, busy
  );

  modport slave (
    input  cpu_as_n, cpu_rw, prog_rom_cs, mem_cs, pal_cs, io_cs, rom_ack,
    output rom_req, cpu_dtack_n, cpu_berr_n, region, busy
  );
endinterface

// File: rtl/m68k_bus_ctrl.sv
// 68000 bus-cycle controller: latches the region on AS, inserts wait states, fetches ROM
// words from the SDRAM arbiter and produces DTACK_n / BERR_n with a watchdog timeout.
module m68k_bus_ctrl #(
  parameter int RAM_WAIT = 1,
  parameter int PAL_WAIT = 2,
  parameter int IO_WAIT  = 0,
  parameter int TIMEOUT  = 255
) (
  input  logic           clk,
  input  logic           reset,
  m68k_bus_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ROM_WAIT,
    S_CNT_WAIT,
    S_ACK,
    S_ERR
  } state_t;

  localparam logic [2:0] REG_NONE = 3'd0;
  localparam logic [2:0] REG_ROM  = 3'd1;
  localparam logic [2:0] REG_MEM  = 3'd2;
  localparam logic [2:0] REG_PAL  = 3'd3;
  localparam logic [2:0] REG_IO   = 3'd4;
  localparam logic [2:0] REG_UNM  = 3'd5;

  localparam logic [7:0] TMO_MAX  = 8'(TIMEOUT);

  state_t     state_q;
  logic [2:0] region_q;
  logic [2:0] region_d;
  logic [7:0] wait_q;
  logic [7:0] wait_d;
  logic [7:0] tmo_q;
  logic       rom_req_q;
  logic       dtack_n_q;
  logic       berr_n_q;
  logic       busy_q;

  always_comb begin
    region_d = REG_UNM;
    if (bus.prog_rom_cs)  region_d = REG_ROM;
    else if (bus.mem_cs)  region_d = REG_MEM;
    else if (bus.pal_cs)  region_d = REG_PAL;
    else if (bus.io_cs)   region_d = REG_IO;
  end

  // ROM writes never reach the arbiter; they are timed like RAM.
  always_comb begin
    wait_d = 8'd0;
    case (region_d)
      REG_ROM: wait_d = 8'(RAM_WAIT);
      REG_MEM: wait_d = 8'(RAM_WAIT);
      REG_PAL: wait_d = 8'(PAL_WAIT);
      REG_IO:  wait_d = 8'(IO_WAIT);
      default: wait_d = 8'd0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      region_q  <= REG_NONE;
      wait_q    <= 8'd0;
      tmo_q     <= 8'd0;
      rom_req_q <= 1'b0;
      dtack_n_q <= 1'b1;
      berr_n_q  <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          tmo_q <= 8'd0;
          if (!bus.cpu_as_n) begin
            region_q <= region_d;
            busy_q   <= 1'b1;
            if (region_d == REG_ROM && bus.cpu_rw) begin
              state_q   <= S_ROM_WAIT;
              rom_req_q <= 1'b1;
            end else begin
              state_q <= S_CNT_WAIT;
              wait_q  <= wait_d;
            end
          end
        end

        // Abort beats a coincident rom_ack; rom_ack beats a coincident timeout.
        S_ROM_WAIT: begin
          if (bus.cpu_as_n) begin
            state_q   <= S_IDLE;
            rom_req_q <= 1'b0;
            region_q  <= REG_NONE;
            busy_q    <= 1'b0;
            tmo_q     <= 8'd0;
          end else if (bus.rom_ack) begin
            state_q   <= S_ACK;
            rom_req_q <= 1'b0;
          end else if (tmo_q == TMO_MAX) begin
            state_q   <= S_ERR;
            rom_req_q <= 1'b0;
            berr_n_q  <= 1'b0;
          end else begin
            tmo_q <= tmo_q + 8'd1;
          end
        end

        S_CNT_WAIT: begin
          if (bus.cpu_as_n) begin
            state_q  <= S_IDLE;
            region_q <= REG_NONE;
            busy_q   <= 1'b0;
            tmo_q    <= 8'd0;
          end else if (region_q != REG_UNM && wait_q == 8'd0) begin
            state_q   <= S_ACK;
            dtack_n_q <= 1'b0;
          end else if (tmo_q == TMO_MAX) begin
            state_q  <= S_ERR;
            berr_n_q <= 1'b0;
          end else begin
            tmo_q <= tmo_q + 8'd1;
            if (region_q != REG_UNM) wait_q <= wait_q - 8'd1;
          end
        end

        S_ACK: begin
          if (bus.cpu_as_n) begin
            state_q   <= S_IDLE;
            dtack_n_q <= 1'b1;
            region_q  <= REG_NONE;
            busy_q    <= 1'b0;
            tmo_q     <= 8'd0;
          end else begin
            dtack_n_q <= 1'b0;
          end
        end

        S_ERR: begin
          if (bus.cpu_as_n) begin
            state_q  <= S_IDLE;
            berr_n_q <= 1'b1;
            region_q <= REG_NONE;
            busy_q   <= 1'b0;
            tmo_q    <= 8'd0;
          end
        end

        default: begin
          state_q   <= S_IDLE;
          rom_req_q <= 1'b0;
          dtack_n_q <= 1'b1;
          berr_n_q  <= 1'b1;
          region_q  <= REG_NONE;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rom_req     = rom_req_q;
  assign bus.cpu_dtack_n = dtack_n_q;
  assign bus.cpu_berr_n  = berr_n_q;
  assign bus.region      = region_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_m68k_bus_ctrl.sv
// Bench for m68k_bus_ctrl: a monitor logs every DTACK/BERR assertion with its latency and
// region, and each scenario compares those events against what it queued when driving.
module tb_m68k_bus_ctrl;

  typedef struct packed {
    logic       berr;
    logic [8:0] lat;
    logic [2:0] region;
  } ev_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   since;
  logic prev_dt;
  logic prev_be;
  ev_t  exp_q[$];
  ev_t  obs_q[$];

  m68k_bus_ctrl_if bus();

  m68k_bus_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count rising edges with AS low; latency is measured from the start edge.
  always @(posedge clk or posedge reset) begin
    if (reset)             since <= 0;
    else if (bus.cpu_as_n) since <= 0;
    else                   since <= since + 1;
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (!bus.cpu_dtack_n && prev_dt) obs_q.push_back({1'b0, 9'(since - 1), bus.region});
      if (!bus.cpu_berr_n  && prev_be) obs_q.push_back({1'b1, 9'(since - 1), bus.region});
    end
    prev_dt = bus.cpu_dtack_n;
    prev_be = bus.cpu_berr_n;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  function automatic ev_t mk_ev(input logic b, input int lat, input logic [2:0] r);
    return {b, 9'(lat), r};
  endfunction

  task automatic drive_idle();
    bus.cpu_as_n    = 1'b1;
    bus.cpu_rw      = 1'b1;
    bus.prog_rom_cs = 1'b0;
    bus.mem_cs      = 1'b0;
    bus.pal_cs      = 1'b0;
    bus.io_cs       = 1'b0;
    bus.rom_ack     = 1'b0;
  endtask

  task automatic start_cycle(input logic rw, input logic rom, input logic mem,
                             input logic pal, input logic io);
    @(negedge clk);
    bus.cpu_rw      = rw;
    bus.prog_rom_cs = rom;
    bus.mem_cs      = mem;
    bus.pal_cs      = pal;
    bus.io_cs       = io;
    bus.cpu_as_n    = 1'b0;
  endtask

  task automatic wait_resp(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (!bus.cpu_dtack_n || !bus.cpu_berr_n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_idle();
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.cpu_dtack_n, bus.cpu_berr_n, bus.rom_req, bus.region, bus.busy} !== 7'b1100000) begin
      errors++;
      $display("FAIL reset_state got dt=%b be=%b req=%b reg=%0d busy=%b required 1 1 0 0 0",
               bus.cpu_dtack_n, bus.cpu_berr_n, bus.rom_req, bus.region, bus.busy);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.cpu_dtack_n, bus.busy} !== 2'b10) begin
      errors++;
      $display("FAIL idle_after_reset got dt=%b busy=%b required 1 0", bus.cpu_dtack_n, bus.busy);
    end
  endtask

  task automatic test_io();
    bit ok;
    ev_t e, o;
    start_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    exp_q.push_back(mk_ev(1'b0, 1, 3'd4));
    wait_resp(20, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL io_resp got no response required dtack"); end
    checks++;
    if (bus.region !== 3'd4) begin errors++; $display("FAIL io_region got %0d required 4", bus.region); end
    drive_idle();
    @(negedge clk);
    checks++;
    if ({bus.cpu_dtack_n, bus.region, bus.busy} !== 5'b10000) begin
      errors++;
      $display("FAIL io_release got dt=%b reg=%0d busy=%b required 1 0 0", bus.cpu_dtack_n, bus.region, bus.busy);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL io_sb got no event required lat=%0d", e.lat); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL io_sb got b=%b lat=%0d reg=%0d required b=%b lat=%0d reg=%0d", o.berr, o.lat, o.region, e.berr, e.lat, e.region); end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL io_sb_extra got %0d required 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_pal_mem();
    bit ok;
    ev_t e, o;
    start_cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    exp_q.push_back(mk_ev(1'b0, 3, 3'd3));
    wait_resp(20, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL pal_resp got no response required dtack"); end
    drive_idle();
    start_cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    exp_q.push_back(mk_ev(1'b0, 2, 3'd2));
    wait_resp(20, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL mem_resp got no response required dtack"); end
    drive_idle();
    @(negedge clk);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL palmem_sb got no event required lat=%0d", e.lat); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL palmem_sb got b=%b lat=%0d reg=%0d required b=%b lat=%0d reg=%0d", o.berr, o.lat, o.region, e.berr, e.lat, e.region); end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL palmem_sb_extra got %0d required 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_rom();
    bit ok;
    bit saw_req;
    ev_t e, o;
    start_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(mk_ev(1'b0, 6, 3'd1));
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checks++;
      if (bus.rom_req !== 1'b1) begin errors++; $display("FAIL rom_req_hold clk %0d got %b required 1", k, bus.rom_req); end
      if (k == 5) bus.rom_ack = 1'b1;
    end
    @(negedge clk);
    bus.rom_ack = 1'b0;
    checks++;
    if ({bus.rom_req, bus.cpu_dtack_n} !== 2'b01) begin
      errors++;
      $display("FAIL rom_drop got req=%b dt=%b required 0 1", bus.rom_req, bus.cpu_dtack_n);
    end
    @(negedge clk);
    checks++;
    if (bus.cpu_dtack_n !== 1'b0) begin errors++; $display("FAIL rom_dtack got %b required 0", bus.cpu_dtack_n); end
    drive_idle();
    start_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(mk_ev(1'b0, 2, 3'd1));
    saw_req = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.rom_req) saw_req = 1'b1;
      if (!bus.cpu_dtack_n) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok || saw_req) begin errors++; $display("FAIL rom_write got ack=%b req_seen=%b required 1 0", ok, saw_req); end
    drive_idle();
    @(negedge clk);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL rom_sb got no event required lat=%0d", e.lat); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL rom_sb got b=%b lat=%0d reg=%0d required b=%b lat=%0d reg=%0d", o.berr, o.lat, o.region, e.berr, e.lat, e.region); end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL rom_sb_extra got %0d required 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_unmapped();
    bit ok;
    ev_t e, o;
    start_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(mk_ev(1'b1, 256, 3'd5));
    wait_resp(300, ok);
    checks++;
    if (!ok || bus.cpu_dtack_n !== 1'b1 || bus.cpu_berr_n !== 1'b0) begin
      errors++;
      $display("FAIL unm_berr got resp=%b dt=%b be=%b required 1 1 0", ok, bus.cpu_dtack_n, bus.cpu_berr_n);
    end
    drive_idle();
    @(negedge clk);
    checks++;
    if ({bus.cpu_berr_n, bus.busy, bus.region} !== 5'b10000) begin
      errors++;
      $display("FAIL unm_release got be=%b busy=%b reg=%0d required 1 0 0", bus.cpu_berr_n, bus.busy, bus.region);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL unm_sb got no event required lat=%0d", e.lat); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL unm_sb got b=%b lat=%0d reg=%0d required b=%b lat=%0d reg=%0d", o.berr, o.lat, o.region, e.berr, e.lat, e.region); end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL unm_sb_extra got %0d required 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_ack_vs_timeout();
    bit ok;
    ev_t e, o;
    start_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(mk_ev(1'b0, 257, 3'd1));
    for (int k = 1; k <= 256; k++) begin
      @(negedge clk);
      if (k == 256) bus.rom_ack = 1'b1;
    end
    @(negedge clk);
    bus.rom_ack = 1'b0;
    checks++;
    if ({bus.cpu_berr_n, bus.rom_req} !== 2'b10) begin
      errors++;
      $display("FAIL tie_no_berr got be=%b req=%b required 1 0", bus.cpu_berr_n, bus.rom_req);
    end
    wait_resp(5, ok);
    drive_idle();
    @(negedge clk);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL tie_sb got no event required lat=%0d", e.lat); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL tie_sb got b=%b lat=%0d reg=%0d required b=%b lat=%0d reg=%0d", o.berr, o.lat, o.region, e.berr, e.lat, e.region); end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL tie_sb_extra got %0d required 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_abort();
    bit ok;
    ev_t e, o;
    start_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    @(negedge clk);
    drive_idle();
    @(negedge clk);
    checks++;
    if ({bus.rom_req, bus.busy} !== 2'b00) begin
      errors++;
      $display("FAIL abort_req got req=%b busy=%b required 0 0", bus.rom_req, bus.busy);
    end
    bus.rom_ack = 1'b1;
    @(negedge clk);
    bus.rom_ack = 1'b0;
    checks++;
    if ({bus.cpu_dtack_n, bus.region, bus.rom_req} !== 5'b10000) begin
      errors++;
      $display("FAIL abort_late_ack got dt=%b reg=%0d req=%b required 1 0 0", bus.cpu_dtack_n, bus.region, bus.rom_req);
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL abort_no_ack got %0d events required 0", obs_q.size()); obs_q.delete(); end
    start_cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    exp_q.push_back(mk_ev(1'b0, 2, 3'd2));
    wait_resp(20, ok);
    drive_idle();
    @(negedge clk);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL abort_sb got no event required lat=%0d", e.lat); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL abort_sb got b=%b lat=%0d reg=%0d required b=%b lat=%0d reg=%0d", o.berr, o.lat, o.region, e.berr, e.lat, e.region); end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL abort_sb_extra got %0d required 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_priority();
    bit ok;
    ev_t e, o;
    start_cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    exp_q.push_back(mk_ev(1'b0, 2, 3'd1));
    @(negedge clk);
    checks++;
    if ({bus.region, bus.rom_req} !== 4'b0011) begin
      errors++;
      $display("FAIL prio_region got reg=%0d req=%b required 1 1", bus.region, bus.rom_req);
    end
    bus.rom_ack = 1'b1;
    @(negedge clk);
    bus.rom_ack = 1'b0;
    wait_resp(10, ok);
    drive_idle();
    @(negedge clk);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL prio_sb got no event required lat=%0d", e.lat); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL prio_sb got b=%b lat=%0d reg=%0d required b=%b lat=%0d reg=%0d", o.berr, o.lat, o.region, e.berr, e.lat, e.region); end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL prio_sb_extra got %0d required 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    ev_t e, o;
    start_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    exp_q.push_back(mk_ev(1'b0, 1, 3'd4));
    wait_resp(20, ok);
    drive_idle();
    start_cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if ({bus.cpu_dtack_n, bus.busy} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_gap got dt=%b busy=%b required 1 0", bus.cpu_dtack_n, bus.busy);
    end
    exp_q.push_back(mk_ev(1'b0, 3, 3'd3));
    wait_resp(20, ok);
    drive_idle();
    @(negedge clk);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL b2b_sb got no event required lat=%0d", e.lat); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL b2b_sb got b=%b lat=%0d reg=%0d required b=%b lat=%0d reg=%0d", o.berr, o.lat, o.region, e.berr, e.lat, e.region); end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL b2b_sb_extra got %0d required 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_reset_mid_ack();
    bit ok;
    ev_t e, o;
    start_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    exp_q.push_back(mk_ev(1'b0, 1, 3'd4));
    wait_resp(20, ok);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.cpu_dtack_n, bus.cpu_berr_n, bus.rom_req, bus.region, bus.busy} !== 7'b1100000) begin
      errors++;
      $display("FAIL reset_mid_ack got dt=%b be=%b req=%b reg=%0d busy=%b required 1 1 0 0 0",
               bus.cpu_dtack_n, bus.cpu_berr_n, bus.rom_req, bus.region, bus.busy);
    end
    drive_idle();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL rst_sb got no event required lat=%0d", e.lat); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL rst_sb got b=%b lat=%0d reg=%0d required b=%b lat=%0d reg=%0d", o.berr, o.lat, o.region, e.berr, e.lat, e.region); end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL rst_sb_extra got %0d required 0", obs_q.size()); obs_q.delete(); end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    prev_dt = 1'b1;
    prev_be = 1'b1;
    test_reset();
    test_io();
    test_pal_mem();
    test_rom();
    test_unmapped();
    test_ack_vs_timeout();
    test_abort();
    test_priority();
    test_back_to_back();
    test_reset_mid_ack();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/m68k_bus_ctrl.md
Name: m68k_bus_ctrl

Overview:
- Consumes the per-PCB M68K chip selects from the address decoder and runs the 68000 bus-cycle handshake: generates DTACK_n/BERR_n, inserts per-region wait states and requests program ROM words from the SDRAM arbiter.
- Sits between the address decoder and the 68000 core.
- Holds the cycle's region classification stable for the whole bus cycle, so downstream read muxes can use it.

Parameters:
- RAM_WAIT, 1, extra clocks before DTACK for work RAM and shared RAM accesses.
- PAL_WAIT, 2, extra clocks before DTACK for tile and sprite palette accesses.
- IO_WAIT, 0, extra clocks before DTACK for register-type selects (scroll, crtc, tile, sprite, flip, vblank, int_en, frame_done, reset_z80).
- TIMEOUT, 255, clocks a cycle may wait without acknowledge before BERR (8-bit counter).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cpu_as_n  in  1  68000 address strobe.
- cpu_rw  in  1  1 = read.
- prog_rom_cs  in  1  program ROM select.
- mem_cs  in  1  OR of ram_cs and shared_ram_cs.
- pal_cs  in  1  OR of tile_palette_cs and sprite_palette_cs.
- io_cs  in  1  OR of all register-type selects.
- rom_ack  in  1  one-clock pulse from SDRAM arbiter: requested ROM word valid.
- rom_req  out  1  level request to SDRAM arbiter; held until rom_ack or abort.
- cpu_dtack_n  out  1  data acknowledge to 68000.
- cpu_berr_n  out  1  bus error to 68000.
- region  out  3  latched cycle class: 0 none, 1 rom, 2 mem, 3 pal, 4 io, 5 unmapped.
- busy  out  1  high while a cycle is in progress (state != IDLE).

Behaviour:
- Reset values (async): state IDLE, cpu_dtack_n=1, cpu_berr_n=1, rom_req=0, region=0, wait counter 0, timeout counter 0.
- Cycle start:
  - In IDLE, a clock with cpu_as_n=0 starts a cycle.
  - Region latches by priority: rom > mem > pal > io > unmapped.
  - Selects are ignored after this latch point.
- State ROM_WAIT:
  - rom_req=1 from the clock after start.
  - On rom_ack: go to ACK, drop rom_req the same edge.
  - Minimum latency from AS low to DTACK low is 2 clocks.
- State CNT_WAIT (mem/pal/io):
  - Load counter with RAM_WAIT, PAL_WAIT or IO_WAIT.
  - Decrement each clock; enter ACK when the counter is 0.
  - A zero wait goes directly to ACK the clock after start, so latency is 1 clock.
- Unmapped region:
  - Stays in CNT_WAIT with the counter held and never acknowledges; only the timeout applies.
- Timeout:
  - The timeout counter runs in ROM_WAIT and CNT_WAIT and clears on entering IDLE.
  - When it reaches TIMEOUT: go to ERR, cpu_berr_n=0, rom_req=0.
- State ACK:
  - cpu_dtack_n=0, held until cpu_as_n=1.
  - Then return to IDLE: cpu_dtack_n=1, region=0, on the same edge that samples as_n high.
- State ERR:
  - cpu_berr_n=0 until cpu_as_n=1, then IDLE.
- Abort: cpu_as_n=1 while in ROM_WAIT or CNT_WAIT causes:
  - immediate return to IDLE and rom_req=0;
  - no DTACK;
  - a rom_ack arriving in that same or a later clock is ignored.
- Simultaneous rom_ack and timeout expiry: rom_ack wins, giving ACK with no BERR.
- Back-to-back cycles: a new cycle can start only from IDLE, so at least one clock with AS high is required between cycles.
- cpu_rw does not change timing. It is carried only so that ROM writes are acknowledged after RAM_WAIT without asserting rom_req; they are classed as region 1.
- cpu_dtack_n and cpu_berr_n are never low simultaneously.
- All outputs are registered.

Test Plan:
- IO cycle, IO_WAIT=0: as_n falls with io_cs=1 -> dtack_n low 1 clock later, region=4; as_n rises -> dtack_n=1 and region=0 next edge.
- Palette cycle, PAL_WAIT=2: pal_cs read -> dtack_n low exactly 3 clocks after AS; mem_cs with RAM_WAIT=1 -> 2 clocks.
- ROM read, rom_ack after 5 clocks -> rom_req high clocks 1..5, drops on ack edge, dtack_n low next edge; ROM write -> no rom_req, dtack after 2 clocks.
- Unmapped access, TIMEOUT=255 -> berr_n low 256 clocks after AS, dtack_n stays 1; AS release -> berr_n=1, busy=0.
- Abort and reset:
  - AS released at clock 3 of a ROM wait, rom_ack at clock 4 -> rom_req=0 at clock 4, no dtack, next cycle normal.
  - reset pulsed mid-ACK -> all outputs at reset values asynchronously.
- Priority: prog_rom_cs and mem_cs both high -> region=1 and rom_req asserted.
